// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC, single-outstanding imem request/grant/response, IF/ID register with skid.
// Optional: FETCH_MISALIGN_TRAP_EN adds MISALIGN and parks fetch on misaligned redirect targets.
module fetch_stage #(
  parameter int unsigned     XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_PC  = '0,
  parameter logic [31:0]     NOP_INSTR = 32'h0000_0013
) (
  input  logic            CLK,
  input  logic            RST,
  output logic            IMEM_REQ,
  output logic [XLEN-1:0] IMEM_ADDR,
  input  logic            IMEM_GNT,
  input  logic            IMEM_RVALID,
  input  logic [31:0]     IMEM_RDATA,
  input  logic            REDIRECT,
  input  logic [XLEN-1:0] REDIRECT_PC,
  input  logic            STALL,
  output logic            IF_VALID,
  output logic [31:0]     IF_INSTR,
  output logic [XLEN-1:0] IF_PC,
  output logic [6:0]      OPCODE,
  output logic [2:0]      FUNCT_THREE,
  output logic [4:0]      FUNCT_FIVE
`ifdef FETCH_MISALIGN_TRAP_EN
  ,
  output logic            MISALIGN
`endif
);

  localparam int unsigned ILEN = 32;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, HOLD} state_t;

  state_t            state;
  logic [XLEN-1:0]   pc;
  logic [XLEN-1:0]   skid_pc;
  logic [ILEN-1:0]   skid_instr;
  logic              kill;

  logic [XLEN-1:0]   redirect_tgt;
  logic [XLEN-1:0]   fetch_addr;
  logic              consume;
  logic              load_rsp;
  logic              load_skid;
  logic              redirect_pend;

  assign redirect_tgt = REDIRECT_PC & ~XLEN'(3);
  assign fetch_addr   = pc & ~XLEN'(3);
  assign consume      = IF_VALID && !STALL;
  assign load_rsp     = (state == WAIT) && IMEM_RVALID && !kill && (!IF_VALID || !STALL);
  assign load_skid    = (state == HOLD) && consume;

  // A request is still outstanding after the redirect edge; its response must be killed.
`ifdef FETCH_MISALIGN_TRAP_EN
  logic tgt_misaligned;
  assign tgt_misaligned = (REDIRECT_PC[1:0] != 2'b00);
  assign redirect_pend  = ((state == WAIT) && !IMEM_RVALID) ||
                          ((state == REQ)  && IMEM_GNT) ||
                          ((state == IDLE) && kill && !IMEM_RVALID);
`else
  assign redirect_pend  = ((state == WAIT) && !IMEM_RVALID) ||
                          ((state == REQ)  && IMEM_GNT);
`endif

  assign OPCODE      = IF_INSTR[6:0];
  assign FUNCT_THREE = IF_INSTR[14:12];
  assign FUNCT_FIVE  = IF_INSTR[31:27];

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state      <= IDLE;
      pc         <= RESET_PC;
      IMEM_REQ   <= 1'b0;
      IMEM_ADDR  <= RESET_PC & ~XLEN'(3);
      IF_VALID   <= 1'b0;
      IF_INSTR   <= NOP_INSTR;
      IF_PC      <= '0;
      skid_instr <= '0;
      skid_pc    <= '0;
      kill       <= 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
      MISALIGN   <= 1'b0;
`endif
    end else if (REDIRECT) begin
      // Flush has priority over stall and any response arriving this cycle.
      pc         <= redirect_tgt;
      IF_VALID   <= 1'b0;
      IF_INSTR   <= NOP_INSTR;
      skid_instr <= '0;
      skid_pc    <= '0;
      kill       <= redirect_pend;
`ifdef FETCH_MISALIGN_TRAP_EN
      MISALIGN   <= tgt_misaligned;
      if (tgt_misaligned) begin
        state    <= IDLE;
        IMEM_REQ <= 1'b0;
      end else
`endif
      if (redirect_pend) begin
        state    <= WAIT;
        IMEM_REQ <= 1'b0;
      end else begin
        state     <= REQ;
        IMEM_REQ  <= 1'b1;
        IMEM_ADDR <= redirect_tgt;
      end
    end else begin
      case (state)
        IDLE: begin
`ifdef FETCH_MISALIGN_TRAP_EN
          // While parked, a killed response may still drain.
          if (kill && IMEM_RVALID) kill <= 1'b0;
          if (!MISALIGN) begin
            state     <= REQ;
            IMEM_REQ  <= 1'b1;
            IMEM_ADDR <= fetch_addr;
          end
`else
          state     <= REQ;
          IMEM_REQ  <= 1'b1;
          IMEM_ADDR <= fetch_addr;
`endif
        end
        REQ: begin
          if (IMEM_GNT) begin
            pc       <= pc + XLEN'(4);
            state    <= WAIT;
            IMEM_REQ <= 1'b0;
          end
        end
        WAIT: begin
          if (IMEM_RVALID) begin
            if (kill || !IF_VALID || !STALL) begin
              kill      <= 1'b0;
              state     <= REQ;
              IMEM_REQ  <= 1'b1;
              IMEM_ADDR <= fetch_addr;
            end else begin
              skid_instr <= IMEM_RDATA;
              skid_pc    <= IMEM_ADDR;
              state      <= HOLD;
            end
          end
        end
        HOLD: begin
          if (consume) begin
            state     <= REQ;
            IMEM_REQ  <= 1'b1;
            IMEM_ADDR <= fetch_addr;
          end
        end
        default: state <= IDLE;
      endcase

      // IF/ID register: new response, then skid drain, then plain consume.
      if (load_rsp) begin
        IF_VALID <= 1'b1;
        IF_INSTR <= IMEM_RDATA;
        IF_PC    <= IMEM_ADDR;
      end else if (load_skid) begin
        IF_VALID <= 1'b1;
        IF_INSTR <= skid_instr;
        IF_PC    <= skid_pc;
      end else if (consume) begin
        IF_VALID <= 1'b0;
        IF_INSTR <= NOP_INSTR;
      end
    end
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction fetch stage that feeds the decode/control stage.
- Holds the PC and fetches 32-bit instructions over a request/grant/response instruction-memory interface, with one outstanding request.
- Presents the instruction and its PC in an IF/ID output register, plus the pre-sliced OPCODE/FUNCT_THREE/FUNCT_FIVE fields that decode consumes.
- Handles decode stall (1-entry skid buffer) and branch/jump redirect (flush plus kill of the in-flight response).

Parameters:
- XLEN, 32, PC and address width.
- RESET_PC, 0, first fetch address after reset.
- NOP_INSTR, 32'h00000013, value driven on IF_INSTR when no valid instruction is held.

Ports:
- CLK  in  1  clock, rising edge.
- RST  in  1  asynchronous, active-high reset.
- IMEM_REQ  out  1  fetch request.
- IMEM_ADDR  out  XLEN  fetch address, word aligned.
- IMEM_GNT  in  1  request accepted this cycle.
- IMEM_RVALID  in  1  response data valid.
- IMEM_RDATA  in  32  response instruction.
- REDIRECT  in  1  branch/jump taken; flush and refetch.
- REDIRECT_PC  in  XLEN  redirect target.
- STALL  in  1  decode cannot accept this cycle.
- IF_VALID  out  1  IF_INSTR/IF_PC hold a valid instruction.
- IF_INSTR  out  32  instruction to decode.
- IF_PC  out  XLEN  PC of IF_INSTR.
- OPCODE  out  7  IF_INSTR[6:0].
- FUNCT_THREE  out  3  IF_INSTR[14:12].
- FUNCT_FIVE  out  5  IF_INSTR[31:27].

Behaviour:
- Reset (asynchronous, RST high): PC=RESET_PC, state=IDLE, IMEM_REQ=0, IMEM_ADDR=RESET_PC, IF_VALID=0, IF_INSTR=NOP_INSTR, IF_PC=0, skid empty, kill=0. Reset mid-transaction drops any outstanding response.
- OPCODE/FUNCT_THREE/FUNCT_FIVE: purely combinational slices of IF_INSTR.
- Consume: IF_VALID && !STALL in a cycle means decode takes the instruction that cycle.
- States:
  - IDLE: go to REQ on the first clock after RST deasserts.
  - REQ: IMEM_REQ=1, IMEM_ADDR=PC. On IMEM_GNT, PC<=PC+4 (wraps mod 2^XLEN) and go to WAIT. ADDR stays stable until GNT, except on REDIRECT.
  - WAIT: IMEM_REQ=0. On IMEM_RVALID:
    - kill=1: discard the data, clear kill, go to REQ.
    - Output slot free or being consumed: load IF_INSTR/IF_PC, set IF_VALID=1, go to REQ.
    - Otherwise: write the data into the skid buffer and go to HOLD.
  - HOLD: IMEM_REQ=0. On consume, move skid contents into the output register (IF_VALID stays 1) and go to REQ.
- Output register: holds its value while IF_VALID && STALL. On consume with no new data, IF_VALID<=0 and IF_INSTR<=NOP_INSTR.
- Latency: GNT in cycle N, RVALID in N+k (k≥1), IF_VALID in N+k+1. Steady-state throughput with k=1 is one instruction per 2 cycles.
- REDIRECT (priority over STALL and RVALID) on a clock edge:
  - PC<=REDIRECT_PC, IF_VALID<=0, IF_INSTR<=NOP_INSTR, skid cleared.
  - In WAIT without RVALID that cycle: kill<=1.
  - In REQ with GNT the same cycle: kill<=1 and go to WAIT.
  - Otherwise: go to REQ.
  - A response arriving in the redirect cycle is dropped.
- Back-to-back redirects: the last one wins. kill is a single flag because there is at most one outstanding request.
- REDIRECT_PC[1:0] is ignored for addressing; IMEM_ADDR[1:0] is always 0.

Optional Feature:
- Macro: FETCH_MISALIGN_TRAP_EN.
- With it: adds output MISALIGN (1 bit, reset 0). A REDIRECT with REDIRECT_PC[1:0]!=0 sets MISALIGN=1 and parks the FSM in IDLE with IMEM_REQ=0 until the next REDIRECT with an aligned target. That aligned redirect clears MISALIGN and resumes normal fetch.
- Without it: no MISALIGN port; low bits are silently masked.

Test Plan:
- Reset release, GNT tied 1, RVALID one cycle after GNT, STALL=0: IMEM_ADDR sequence 0x0,0x4,0x8. IF_PC 0x0 appears 2 cycles after the first GNT with IF_INSTR=RDATA. OPCODE/FUNCT_THREE/FUNCT_FIVE match the slices.
- STALL=1 for 5 cycles while the next response arrives: IF_INSTR/IF_PC hold. The response goes to skid and IMEM_REQ stays 0. On STALL drop, the skid instruction appears next cycle with no loss and no duplication.
- REDIRECT to 0x100 while in WAIT: IF_VALID=0 next cycle. The in-flight RDATA is discarded. The next IMEM_ADDR is 0x100 and IF_PC=0x100 is the next valid output.
- REDIRECT asserted with STALL=1 and RVALID=1 in the same cycle: flush wins. The response is dropped and IF_VALID=0.
- PC=0xFFFFFFFC granted: next IMEM_ADDR=0x00000000.
- FETCH_MISALIGN_TRAP_EN: REDIRECT_PC=0x102 sets MISALIGN=1 and IMEM_REQ=0. A later REDIRECT_PC=0x200 clears MISALIGN and the next fetch address is 0x200.
